// File: rtl/noc_pkg.sv
// noc_pkg: shared direction encoding and route FSM states for the XY route unit
package noc_pkg;
  localparam int DIR_E = 0;
  localparam int DIR_W = 1;
  localparam int DIR_N = 2;
  localparam int DIR_S = 3;
  localparam int DIR_L = 4;
  typedef logic [4:0] dir_t;
  typedef enum logic [1:0] {IDLE, BUSY, DROP} route_state_t;
endpackage

// File: rtl/xy_route_calc.sv
// xy_route_calc: combinational XY (optionally torus shortest-path) direction decode with range check
module xy_route_calc
  import noc_pkg::*;
#(
  parameter int MESH_X  = 3,
  parameter int MESH_Y  = 3,
  parameter int WRAP_EN = 1
) (
  input  logic [31:0] i_x_cur,
  input  logic [31:0] i_y_cur,
  input  logic [31:0] i_x_final,
  input  logic [31:0] i_y_final,
  output dir_t        o_dir,
  output logic        o_dest_ok
);
  logic [1:0] w_x;
  logic [1:0] w_y;
  // returns {negative step, positive step}; with wrap, ties go the positive way
  function automatic logic [1:0] axis_step(input logic [31:0] c, input logic [31:0] f, input logic [31:0] m);
    logic [31:0] fwd;
    logic [31:0] bwd;
    fwd = (f >= c) ? (f - c) % m : (m - (c - f) % m) % m;
    bwd = m - fwd;
    return (WRAP_EN != 0) ? {fwd != 0 && fwd > bwd, fwd != 0 && fwd <= bwd} : {f < c, f > c};
  endfunction
  assign w_x       = axis_step(i_x_cur, i_x_final, 32'(MESH_X));
  assign w_y       = axis_step(i_y_cur, i_y_final, 32'(MESH_Y));
  assign o_dir     = (w_x != 2'b00) ? {3'b000, w_x} :
                     (w_y != 2'b00) ? {1'b0, w_y, 2'b00} : dir_t'(1 << DIR_L);
  assign o_dest_ok = (i_x_final < 32'(MESH_X)) && (i_y_final < 32'(MESH_Y));
endmodule

// File: rtl/xy_route_unit.sv
// xy_route_unit: per-packet XY route lock and registered valid/ready steering; XY_ROUTE_DROP_CNT_EN adds drop_cnt/drop_pulse
module xy_route_unit
  import noc_pkg::*;
#(
  parameter int MESH_X  = 3,
  parameter int MESH_Y  = 3,
  parameter int COORD_W = 7,
  parameter int DATA_W  = 32,
  parameter int WRAP_EN = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       x_cur,
  input  logic [31:0]       y_cur,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              out_valid,
  output dir_t              out_dir,
`ifdef XY_ROUTE_DROP_CNT_EN
  output logic [15:0]       drop_cnt,
  output logic [0:0]        drop_pulse,
`endif
  input  dir_t              out_ready
);
  route_state_t      r_state;
  route_state_t      w_nxt;
  dir_t              r_lock;
  dir_t              r_dir;
  dir_t              w_dir;
  dir_t              w_ndir;
  logic [DATA_W-1:0] r_data;
  logic              r_last;
  logic              r_valid;
  logic              w_ok;
  logic              w_acc;
  logic              w_head;
  logic              w_load;
  logic              w_drop;

  xy_route_calc #(
    .MESH_X (MESH_X),
    .MESH_Y (MESH_Y),
    .WRAP_EN(WRAP_EN)
  ) u_calc (
    .i_x_cur  (x_cur),
    .i_y_cur  (y_cur),
    .i_x_final(32'(in_data[COORD_W-1:0])),
    .i_y_final(32'(in_data[2*COORD_W-1:COORD_W])),
    .o_dir    (w_dir),
    .o_dest_ok(w_ok)
  );

  assign in_ready  = !reset && (r_state == DROP || !r_valid || |(r_dir & out_ready));
  assign w_acc     = in_valid && in_ready;
  assign out_data  = r_data;
  assign out_last  = r_last;
  assign out_valid = r_valid;
  assign out_dir   = r_dir;

  // next state: only an accepted flit moves the FSM, and an accepted tail always returns to IDLE
  always_comb begin
    w_head = r_state == IDLE;
    w_drop = w_acc && w_head && !w_ok;
    w_load = w_acc && (r_state == BUSY || (w_head && w_ok));
    w_ndir = w_head ? w_dir : r_lock;
    w_nxt  = !w_acc ? r_state : in_last ? IDLE : w_head ? (w_ok ? BUSY : DROP) : r_state;
  end

  // state register and direction locked at a routable head
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_lock  <= '0;
    end else begin
      r_state <= w_nxt;
      if (w_acc && w_head && w_ok) r_lock <= w_dir;
    end
  end

  // output register: refill on accept, otherwise empty once the selected port takes the flit
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_data  <= '0;
      r_dir   <= '0;
    end else if (w_load) begin
      r_valid <= 1'b1;
      r_last  <= in_last;
      r_data  <= in_data;
      r_dir   <= w_ndir;
    end else if (|(r_dir & out_ready)) begin
      r_valid <= 1'b0;
    end
  end

`ifdef XY_ROUTE_DROP_CNT_EN
  // saturating count of dropped packets, bumped at the head accept
  always_ff @(posedge clk) begin
    if (reset) begin
      drop_cnt   <= '0;
      drop_pulse <= 1'b0;
    end else begin
      drop_pulse <= w_drop;
      if (w_drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
    end
  end
`else
  logic w_unused;
  assign w_unused = w_drop;
`endif
endmodule

// File: tb/tb_xy_route_unit.sv
// tb_xy_route_unit: randomized and directed checks of xy_route_unit against a packet-level reference model
module tb_xy_route_unit;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] x_cur = '0;
  logic [31:0] y_cur = '0;
  logic [31:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic [4:0]  out_ready = 5'h1f;
  logic        in_ready, out_last, out_valid;
  logic [31:0] out_data;
  logic [4:0]  out_dir;
  logic        w_in_ready, w_out_last, w_out_valid;
  logic [31:0] w_out_data;
  logic [4:0]  w_out_dir;
  logic        n_in_ready, n_out_last, n_out_valid;
  logic [31:0] n_out_data;
  logic [4:0]  n_out_dir;
`ifdef XY_ROUTE_DROP_CNT_EN
  logic [15:0] drop_cnt, w_drop_cnt, n_drop_cnt;
  logic [0:0]  drop_pulse, w_drop_pulse, n_drop_pulse;
`endif

  int n_checks = 0;
  int n_err = 0;
  int cyc = 0;

  typedef struct packed {
    logic [31:0] d;
    logic        l;
    logic [4:0]  dir;
  } flit_t;
  flit_t exp_q[$];
  flit_t got_q[$];
  int    got_cyc[$];

  xy_route_unit #(.MESH_X(3), .MESH_Y(3), .COORD_W(7), .DATA_W(32), .WRAP_EN(1)) u_dut (
    .clk(clk), .reset(reset), .x_cur(x_cur), .y_cur(y_cur), .in_data(in_data),
    .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready), .out_data(out_data),
    .out_last(out_last), .out_valid(out_valid), .out_dir(out_dir),
`ifdef XY_ROUTE_DROP_CNT_EN
    .drop_cnt(drop_cnt), .drop_pulse(drop_pulse),
`endif
    .out_ready(out_ready)
  );

  xy_route_unit #(.MESH_X(4), .MESH_Y(4), .COORD_W(7), .DATA_W(32), .WRAP_EN(1)) u_m4w (
    .clk(clk), .reset(reset), .x_cur(x_cur), .y_cur(y_cur), .in_data(in_data),
    .in_valid(in_valid), .in_last(in_last), .in_ready(w_in_ready), .out_data(w_out_data),
    .out_last(w_out_last), .out_valid(w_out_valid), .out_dir(w_out_dir),
`ifdef XY_ROUTE_DROP_CNT_EN
    .drop_cnt(w_drop_cnt), .drop_pulse(w_drop_pulse),
`endif
    .out_ready(out_ready)
  );

  xy_route_unit #(.MESH_X(4), .MESH_Y(4), .COORD_W(7), .DATA_W(32), .WRAP_EN(0)) u_m4n (
    .clk(clk), .reset(reset), .x_cur(x_cur), .y_cur(y_cur), .in_data(in_data),
    .in_valid(in_valid), .in_last(in_last), .in_ready(n_in_ready), .out_data(n_out_data),
    .out_last(n_out_last), .out_valid(n_out_valid), .out_dir(n_out_dir),
`ifdef XY_ROUTE_DROP_CNT_EN
    .drop_cnt(n_drop_cnt), .drop_pulse(n_drop_pulse),
`endif
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk)
    if (!reset && out_valid && (out_dir & out_ready) != 5'b0) begin
      got_q.push_back({out_data, out_last, out_dir});
      got_cyc.push_back(cyc);
    end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic int step(input int c, input int f, input int m, input bit wrap);
    int fwd;
    if (f == c) return 0;
    if (!wrap) return (f > c) ? 1 : -1;
    fwd = ((f - c) % m + m) % m;
    return (2 * fwd <= m) ? 1 : -1;
  endfunction

  function automatic logic [4:0] ref_route(input int xc, input int yc, input int xf, input int yf,
                                           input int mx, input int my, input bit wrap);
    int sx, sy;
    sx = step(xc, xf, mx, wrap);
    sy = step(yc, yf, my, wrap);
    if (sx == 1) return 5'b00001;
    if (sx == -1) return 5'b00010;
    if (sy == 1) return 5'b00100;
    if (sy == -1) return 5'b01000;
    return 5'b10000;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_cur(input int x, input int y);
    x_cur = x;
    y_cur = y;
    out_ready = 5'h1f;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_q.delete();
    got_q.delete();
    got_cyc.delete();
  endtask

  task automatic send_flit(input logic [31:0] d, input logic l, input bit rnd);
    int w;
    w = 0;
    in_data = d;
    in_last = l;
    in_valid = 1'b1;
    forever begin
      if (rnd) out_ready = ($urandom_range(0, 2) == 0) ? 5'($urandom) : 5'h1f;
      @(negedge clk);
      if (in_ready) break;
      w++;
      if (w > 200) begin
        n_checks++;
        n_err++;
        $display("FAIL accept_timeout: in_ready=%b required 1 within 200 cycles", in_ready);
        break;
      end
      @(posedge clk);
      #1;
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic send_pkt(input int xf, input int yf, input int len, input bit rnd);
    logic [31:0] d;
    logic [4:0]  dir;
    bit          ok;
    dir = ref_route(int'(x_cur), int'(y_cur), xf, yf, 3, 3, 1'b1);
    ok = (xf < 3) && (yf < 3);
    for (int i = 0; i < len; i++) begin
      d = $urandom;
      if (i == 0) d[13:0] = {7'(yf), 7'(xf)};
      if (ok) exp_q.push_back({d, 1'(i == len - 1), dir});
      send_flit(d, 1'(i == len - 1), rnd);
    end
  endtask

  task automatic drain;
    out_ready = 5'h1f;
    repeat (4) tick();
  endtask

  task automatic compare_q(input string name);
    n_checks++;
    if (got_q.size() != exp_q.size()) begin
      n_err++;
      $display("FAIL %s_count: got %0d flits, required %0d", name, got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL %s_flit%0d: got d=%h l=%b dir=%b, required d=%h l=%b dir=%b", name, i,
                 got_q[i].d, got_q[i].l, got_q[i].dir, exp_q[i].d, exp_q[i].l, exp_q[i].dir);
      end
    end
    exp_q.delete();
    got_q.delete();
    got_cyc.delete();
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick();
    n_checks += 5;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b required 0", out_valid); end
    if (out_last !== 1'b0) begin n_err++; $display("FAIL reset_last: got %b required 0", out_last); end
    if (out_data !== 32'h0) begin n_err++; $display("FAIL reset_data: got %h required 0", out_data); end
    if (out_dir !== 5'b0) begin n_err++; $display("FAIL reset_dir: got %b required 00000", out_dir); end
    if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready: got %b required 0", in_ready); end
    reset = 1'b0;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL post_reset_in_ready: got %b required 1", in_ready); end
  endtask

  task automatic test_single;
    int          xs[3] = '{2, 1, 0};
    int          ys[3] = '{1, 0, 0};
    logic [4:0]  ds[3] = '{5'b00010, 5'b00001, 5'b10000};
    set_cur(0, 0);
    for (int i = 0; i < 3; i++) begin
      send_pkt(xs[i], ys[i], 1, 1'b0);
      n_checks += 2;
      if (out_valid !== 1'b1) begin n_err++; $display("FAIL single%0d_valid: got %b required 1", i, out_valid); end
      if (out_dir !== ds[i]) begin n_err++; $display("FAIL single%0d_dir: got %b required %b", i, out_dir, ds[i]); end
    end
    drain();
    compare_q("single");
  endtask

  task automatic test_stall;
    logic [31:0] d;
    set_cur(1, 1);
    d = $urandom;
    d[13:0] = {7'd2, 7'd1};
    exp_q.push_back({d, 1'b0, 5'b00100});
    send_flit(d, 1'b0, 1'b0);
    d = {$urandom} & 32'hFFFF_C000;
    exp_q.push_back({d, 1'b0, 5'b00100});
    send_flit(d, 1'b0, 1'b0);
    out_ready = 5'b11011;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks += 3;
      if (in_ready !== 1'b0) begin n_err++; $display("FAIL stall%0d_in_ready: got %b required 0", i, in_ready); end
      if (out_valid !== 1'b1) begin n_err++; $display("FAIL stall%0d_valid: got %b required 1", i, out_valid); end
      if (out_data !== d || out_dir !== 5'b00100)
        begin n_err++; $display("FAIL stall%0d_hold: got d=%h dir=%b required d=%h dir=00100", i, out_data, out_dir, d); end
      tick();
    end
    out_ready = 5'h1f;
    for (int i = 0; i < 2; i++) begin
      d = {$urandom} & 32'hFFFF_C000;
      exp_q.push_back({d, 1'(i == 1), 5'b00100});
      send_flit(d, 1'(i == 1), 1'b0);
    end
    drain();
    compare_q("stall");
  endtask

  task automatic test_back_to_back;
    set_cur(0, 0);
    send_pkt(1, 0, 2, 1'b0);
    send_pkt(0, 0, 2, 1'b0);
    drain();
    n_checks++;
    if (got_cyc.size() != 4) begin
      n_err++;
      $display("FAIL b2b_cycles: got %0d output cycles, required 4", got_cyc.size());
    end else
      for (int i = 1; i < 4; i++) begin
        n_checks++;
        if (got_cyc[i] - got_cyc[i-1] != 1) begin
          n_err++;
          $display("FAIL b2b_gap%0d: got gap %0d required 1", i, got_cyc[i] - got_cyc[i-1]);
        end
      end
    compare_q("b2b");
  endtask

  task automatic test_mesh4;
    set_cur(0, 0);
    send_pkt(2, 0, 1, 1'b0);
    n_checks++;
    if (w_out_valid !== 1'b1 || w_out_dir !== 5'b00001)
      begin n_err++; $display("FAIL m4_wrap_tie: got v=%b dir=%b required v=1 dir=00001", w_out_valid, w_out_dir); end
    send_pkt(3, 0, 1, 1'b0);
    n_checks++;
    if (n_out_valid !== 1'b1 || n_out_dir !== 5'b00001)
      begin n_err++; $display("FAIL m4_nowrap: got v=%b dir=%b required v=1 dir=00001", n_out_valid, n_out_dir); end
    n_checks++;
    if (w_out_dir !== 5'b00010)
      begin n_err++; $display("FAIL m4_wrap_west: got dir=%b required 00010", w_out_dir); end
    drain();
    compare_q("m4_main");
  endtask

  task automatic test_drop;
    logic [31:0] d;
    set_cur(0, 0);
    for (int i = 0; i < 3; i++) begin
      d = $urandom;
      if (i == 0) d[13:0] = {7'd0, 7'd5};
      in_data = d;
      in_last = 1'(i == 2);
      in_valid = 1'b1;
      @(negedge clk);
      n_checks += 2;
      if (in_ready !== 1'b1) begin n_err++; $display("FAIL drop%0d_in_ready: got %b required 1", i, in_ready); end
      if (out_valid !== 1'b0) begin n_err++; $display("FAIL drop%0d_valid: got %b required 0", i, out_valid); end
      tick();
`ifdef XY_ROUTE_DROP_CNT_EN
      n_checks++;
      if (drop_pulse !== 1'(i == 0)) begin n_err++; $display("FAIL drop%0d_pulse: got %b required %b", i, drop_pulse, i == 0); end
`endif
    end
    in_valid = 1'b0;
`ifdef XY_ROUTE_DROP_CNT_EN
    n_checks++;
    if (drop_cnt !== 16'd1) begin n_err++; $display("FAIL drop_cnt: got %0d required 1", drop_cnt); end
`endif
    send_pkt(0, 0, 1, 1'b0);
    n_checks++;
    if (out_valid !== 1'b1 || out_dir !== 5'b10000)
      begin n_err++; $display("FAIL drop_then_head: got v=%b dir=%b required v=1 dir=10000", out_valid, out_dir); end
    drain();
    compare_q("drop");
  endtask

  task automatic test_reset_busy;
    logic [31:0] d;
    set_cur(0, 0);
    d = 32'h0;
    d[13:0] = {7'd0, 7'd1};
    send_flit(d, 1'b0, 1'b0);
    send_flit($urandom, 1'b0, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_busy_valid: got %b required 0", out_valid); end
    exp_q.delete();
    got_q.delete();
    got_cyc.delete();
    send_pkt(0, 0, 1, 1'b0);
    n_checks++;
    if (out_valid !== 1'b1 || out_dir !== 5'b10000)
      begin n_err++; $display("FAIL rst_busy_head: got v=%b dir=%b required v=1 dir=10000", out_valid, out_dir); end
    drain();
    compare_q("rst_busy");
  endtask

  task automatic test_random;
    for (int p = 0; p < 3; p++) begin
      set_cur($urandom_range(0, 2), $urandom_range(0, 2));
      for (int k = 0; k < 40; k++)
        send_pkt($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(1, 4), 1'b1);
      drain();
      compare_q("random");
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_stall();
    test_back_to_back();
    test_mesh4();
    test_drop();
    test_reset_busy();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule

// File: doc/xy_route_unit.md
Name: xy_route_unit

Overview:
- Packet-level XY route-compute and steering stage at each router input port. Next generation of the router's combinational XY direction decoder.
- Parametrised in mesh size and coordinate width; optional torus shortest-path wrap.
- Decodes the destination from the head flit, locks the direction for the whole packet, and forwards flits through a one-stage registered valid/ready pipeline.
- Drops packets whose destination lies outside the mesh.

Parameters:
- MESH_X, 3, number of columns; legal x is 0..MESH_X-1.
- MESH_Y, 3, number of rows; legal y is 0..MESH_Y-1.
- COORD_W, 7, width of each destination coordinate field in the head flit.
- DATA_W, 32, flit width; must be >= 2*COORD_W.
- WRAP_EN, 1, 1 = torus shortest-path with wrap links; 0 = plain mesh.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- x_cur  in  32  this router's x coordinate; static after reset.
- y_cur  in  32  this router's y coordinate; static after reset.
- in_data  in  DATA_W  flit. On a head flit, x_final = [COORD_W-1:0] and y_final = [2*COORD_W-1:COORD_W].
- in_valid  in  1  upstream flit valid.
- in_last  in  1  tail flit marker.
- in_ready  out  1  flit accepted when in_valid && in_ready.
- out_data  out  DATA_W  registered flit.
- out_last  out  1  registered tail marker.
- out_valid  out  1  output flit valid.
- out_dir  out  5  one-hot direction: [0] east, [1] west, [2] north (y+), [3] south (y-), [4] local IP.
- out_ready  in  5  per-direction downstream ready; only the bit selected by out_dir is used.

Behaviour:
- Reset (one clk edge with reset=1):
  - out_valid=0, out_last=0, out_data=0, out_dir=0.
  - FSM goes to IDLE; locked direction register cleared.
  - A packet interrupted by reset is abandoned; the next accepted flit is treated as a head.
- Output handshake:
  - in_ready = reset ? 0 : (state==DROP) || !out_valid || |(out_dir & out_ready).
  - Latency is 1 cycle. Throughput is 1 flit/cycle while the selected out_ready stays high.
  - out_data, out_last and out_dir hold stable while out_valid && !selected ready.
  - On an output transfer with no new accept, out_valid falls to 0.
  - Simultaneous output transfer and input accept refill the output register in the same edge; there is no bubble.
- Route computation (combinational, from head flit and x_cur/y_cur):
  - X is resolved first, then Y; dx==dy==0 selects local.
  - WRAP_EN=0: xf>xc → east, xf<xc → west. yf>yc → north, yf<yc → south.
  - WRAP_EN=1: fwd=(xf-xc) mod MESH_X, bwd=MESH_X-fwd.
    - fwd!=0 && fwd<=bwd → east; fwd!=0 && fwd>bwd → west.
    - The tie goes to east/north.
    - Y uses the same rule with MESH_Y, north/south.
  - Arithmetic is done at 32 bits on zero-extended coordinates.
- FSM states are IDLE, BUSY and DROP.
  - IDLE, head accepted with xf>=MESH_X or yf>=MESH_Y: the flit is not forwarded. If !in_last go to DROP, else stay in IDLE.
  - IDLE, valid head accepted: the flit is loaded into the output register with the computed out_dir, and that direction is locked. If !in_last go to BUSY, else stay in IDLE (single-flit packet).
  - BUSY: each accepted flit is loaded with the locked direction; the destination fields are not re-decoded. Accepting in_last returns the FSM to IDLE.
  - DROP: in_ready=1 and every flit is consumed with no output. Accepting in_last returns the FSM to IDLE.
- in_valid=0 holds the FSM state. in_last is ignored unless the flit is accepted.

Optional Feature:
- Macro: XY_ROUTE_DROP_CNT_EN.
- Defined:
  - Adds output drop_cnt [15:0], which increments once per dropped packet, at the head accept in IDLE.
  - The counter saturates at 16'hFFFF and is cleared by reset.
  - Adds output drop_pulse [0:0], high for the single cycle of that increment.
- Undefined: no extra ports or registers; drop behaviour is identical.

Decomposition:
- Package noc_pkg holds:
  - direction index constants DIR_E=0, DIR_W=1, DIR_N=2, DIR_S=3, DIR_L=4;
  - typedef dir_t (logic [4:0]);
  - FSM enum route_state_t {IDLE, BUSY, DROP}.
- Sub-module xy_route_calc is purely combinational. It takes MESH_X, MESH_Y and WRAP_EN, has inputs cur/final coordinates, and outputs dir_t plus dest_ok.
- xy_route_unit holds the FSM, the direction lock and the output register.

Test Plan:
- Single-flit packets, 3x3 mesh, WRAP_EN=1, at cur (0,0):
  - dest (2,1) → out_dir=00010 (west via wrap), 1 cycle after accept.
  - dest (1,0) → 00001.
  - dest (0,0) → 10000.
- 4-flit packet, cur (1,1), dest (1,2), with out_ready[2] held low for 3 cycles mid-packet:
  - all 4 flits exit on 00100 in order with data stable while stalled;
  - in_ready stays low while stalled;
  - the body-flit low bits 0x0 do not change direction.
- Back-to-back 2-flit packets to east then local, all ready=1:
  - 4 consecutive output cycles, no bubble;
  - out_dir switches 00001 → 10000 at the second head.
- 4x4 mesh, cur (0,0):
  - WRAP_EN=1, dest (2,0) → 00001 (tie goes east);
  - WRAP_EN=0, dest (3,0) → 00001.
- 3-flit packet with dest (5,0) on 3x3:
  - no out_valid; in_ready=1 throughout; FSM back to IDLE after the tail;
  - with XY_ROUTE_DROP_CNT_EN defined, drop_cnt=1.
- reset asserted during BUSY:
  - next edge gives out_valid=0 and IDLE;
  - the next flit with dest (0,0) is routed as a head → 10000.
